// File: rtl/intra4x4_mode_sched_if.sv
// Handshake bundle between the intra 4x4 mode scheduler, its block controller and SAD datapath.
interface intra4x4_mode_sched_if #(
  parameter int unsigned SAD_W = 12
);
  logic             start;
  logic             avail_top;
  logic             avail_left;
  logic             avail_topleft;
  logic             mode_req;
  logic [3:0]       mode_sel;
  logic             sad_valid;
  logic [SAD_W-1:0] sad_in;
  logic             busy;
  logic             done;
  logic [3:0]       best_mode;
  logic [SAD_W-1:0] best_sad;
  logic [8:0]       tested;

  modport master (
    output start, avail_top, avail_left, avail_topleft, sad_valid, sad_in,
    input  mode_req, mode_sel, busy, done, best_mode, best_sad, tested
  );

  modport slave (
    input  start, avail_top, avail_left, avail_topleft, sad_valid, sad_in,
    output mode_req, mode_sel, busy, done, best_mode, best_sad, tested
  );
endinterface

// File: rtl/intra4x4_mode_sched.sv
// Sequences the nine 4x4 luma intra modes of one block and keeps the lowest-SAD mode.
// Define INTRA4X4_EARLY_TERM_EN to stop once the best SAD falls to EARLY_THR or below.
module intra4x4_mode_sched #(
  parameter int unsigned SAD_W     = 12,
  parameter int unsigned EARLY_THR = 64
) (
  input logic                  clk,
  input logic                  reset,
  intra4x4_mode_sched_if.slave bus
);

`ifdef INTRA4X4_EARLY_TERM_EN
  localparam bit EarlyTermEn = 1'b1;
`else
  localparam bit EarlyTermEn = 1'b0;
`endif
  localparam logic [SAD_W-1:0] EarlyThr = SAD_W'(EARLY_THR);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [8:0]       pend_q;
  logic [8:0]       tested_q;
  logic [3:0]       mode_sel_q;
  logic [3:0]       best_mode_q;
  logic [SAD_W-1:0] best_sad_q;

  logic [8:0]       elig;
  logic [3:0]       first_mode;
  logic             take;
  logic [SAD_W-1:0] cand_sad;

  // Eligibility from the neighbour flags; DC (mode 2) needs no neighbours.
  always_comb begin
    elig    = 9'b0_0000_0100;
    elig[0] = bus.avail_top;
    elig[3] = bus.avail_top;
    elig[7] = bus.avail_top;
    elig[1] = bus.avail_left;
    elig[8] = bus.avail_left;
    elig[4] = bus.avail_top & bus.avail_left & bus.avail_topleft;
    elig[5] = bus.avail_top & bus.avail_left & bus.avail_topleft;
    elig[6] = bus.avail_top & bus.avail_left & bus.avail_topleft;
  end

  always_comb begin
    first_mode = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (pend_q[i]) first_mode = 4'(i);
    end
  end

  // An empty tested mask marks the first result of the block; strict compare keeps ties low.
  always_comb begin
    take     = (tested_q == 9'd0) || (bus.sad_in < best_sad_q);
    cand_sad = take ? bus.sad_in : best_sad_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.sad_valid) begin
          if (pend_q != 9'd0 && !(EarlyTermEn && cand_sad <= EarlyThr)) state_d = StIssue;
          else                                                          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mode_req = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.mode_sel = mode_sel_q;
    case (state_q)
      StIdle:  bus.busy = 1'b0;
      StIssue: begin
        bus.mode_req = 1'b1;
        bus.mode_sel = first_mode;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= 9'd0;
      tested_q    <= 9'd0;
      mode_sel_q  <= 4'd0;
      best_mode_q <= 4'd2;
      best_sad_q  <= '1;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            pend_q      <= elig;
            tested_q    <= 9'd0;
            best_mode_q <= 4'd2;
            best_sad_q  <= '1;
          end
        end
        StIssue: begin
          pend_q[first_mode] <= 1'b0;
          mode_sel_q         <= first_mode;
        end
        StWait: begin
          if (bus.sad_valid) begin
            tested_q[mode_sel_q] <= 1'b1;
            if (take) begin
              best_mode_q <= mode_sel_q;
              best_sad_q  <= bus.sad_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.tested    = tested_q;

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Scoreboard bench for intra4x4_mode_sched: expected mode order and results queued per block.
module tb_intra4x4_mode_sched;
  localparam int unsigned SadW = 12;

  typedef int sad_arr_t [9];
  typedef struct {
    int mode;
    int sad;
    int tested;
    int cycles;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  intra4x4_mode_sched_if #(.SAD_W(SadW)) bus ();

  intra4x4_mode_sched #(
    .SAD_W    (SadW),
    .EARLY_THR(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   mode_q[$];
  res_t res_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: issue order, best mode/SAD, tested mask and done latency.
  task automatic push_expect(input logic t, input logic l, input logic tl, input sad_arr_t sads,
                             input int lat);
    logic [8:0] elig;
    int best_m, best_s, tst, n;
    elig = 9'd0;
    elig[2] = 1'b1;
    if (t) begin elig[0] = 1'b1; elig[3] = 1'b1; elig[7] = 1'b1; end
    if (l) begin elig[1] = 1'b1; elig[8] = 1'b1; end
    if (t && l && tl) begin elig[4] = 1'b1; elig[5] = 1'b1; elig[6] = 1'b1; end
    best_m = 2; best_s = 4095; tst = 0; n = 0;
    for (int k = 0; k < 9; k++) begin
      if (elig[k]) begin
        mode_q.push_back(k);
        if (n == 0 || sads[k] < best_s) begin
          best_m = k;
          best_s = sads[k];
        end
        n++;
        tst = tst | (1 << k);
`ifdef INTRA4X4_EARLY_TERM_EN
        if (best_s <= 64) break;
`endif
      end
    end
    res_q.push_back('{best_m, best_s, tst, n * (1 + lat) + 1});
  endtask

  task automatic run_block(input string name, input logic t, input logic l, input logic tl,
                           input sad_arr_t sads, input int lat, input int abort_at);
    int   cyc, cnt, m;
    bit   fin;
    res_t r;
    push_expect(t, l, tl, sads, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.avail_top = t;
    bus.avail_left = l;
    bus.avail_topleft = tl;
    @(negedge clk);
    bus.start = 1'b0;
    bus.avail_top = 1'b0;
    bus.avail_left = 1'b0;
    bus.avail_topleft = 1'b0;
    check_eq({name, " busy_t1"}, bus.busy, 1);
    check_eq({name, " req_t1"}, bus.mode_req, 1);
    cyc = 1; cnt = 0; m = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      if (bus.mode_req) begin
        if (mode_q.size() == 0) check_eq({name, " extra_req"}, bus.mode_sel, 15);
        else                    check_eq({name, " mode_sel"}, bus.mode_sel, mode_q.pop_front());
        m = int'(bus.mode_sel);
        cnt = lat;
      end
      if (abort_at >= 0 && bus.mode_req && int'(bus.mode_sel) == abort_at) begin
        @(negedge clk);
        check_eq({name, " busy_wait"}, bus.busy, 1);
        reset = 1'b0;
        #1;
        check_eq({name, " rst_busy"}, bus.busy, 0);
        check_eq({name, " rst_tested"}, bus.tested, 0);
        check_eq({name, " rst_req"}, bus.mode_req, 0);
        check_eq({name, " rst_best_mode"}, bus.best_mode, 2);
        check_eq({name, " rst_best_sad"}, bus.best_sad, 4095);
        check_eq({name, " rst_mode_sel"}, bus.mode_sel, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.sad_valid = 1'b1;
        bus.sad_in = 12'd5;
        @(negedge clk);
        bus.sad_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
          check_eq({name, " stray_done"}, bus.done, 0);
          check_eq({name, " stray_busy"}, bus.busy, 0);
          check_eq({name, " stray_tested"}, bus.tested, 0);
          @(negedge clk);
        end
        mode_q.delete();
        res_q.delete();
        fin = 1'b1;
      end else if (bus.done) begin
        r = res_q.pop_front();
        check_eq({name, " done_cycle"}, cyc, r.cycles);
        check_eq({name, " best_mode"}, bus.best_mode, r.mode);
        check_eq({name, " best_sad"}, bus.best_sad, r.sad);
        check_eq({name, " tested"}, bus.tested, r.tested);
        check_eq({name, " busy_done"}, bus.busy, 1);
        check_eq({name, " modes_left"}, mode_q.size(), 0);
        bus.start = 1'b1;  // must be ignored while in the done state
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({name, " done_pulse"}, bus.done, 0);
        check_eq({name, " busy_after"}, bus.busy, 0);
        check_eq({name, " tested_hold"}, bus.tested, r.tested);
        check_eq({name, " best_hold"}, bus.best_mode, r.mode);
        check_eq({name, " mode_sel_hold"}, bus.mode_sel, m);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        bus.sad_valid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.sad_valid = 1'b1;
            bus.sad_in = sads[m][SadW-1:0];
          end
        end
      end
    end
    if (!fin) begin
      check_eq({name, " timeout"}, 0, 1);
      mode_q.delete();
      res_q.delete();
    end
    bus.sad_valid = 1'b0;
  endtask

  initial begin
    sad_arr_t s;
    bus.start = 1'b0;
    bus.avail_top = 1'b0;
    bus.avail_left = 1'b0;
    bus.avail_topleft = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in = '0;
    @(negedge clk);
    check_eq("reset busy", bus.busy, 0);
    check_eq("reset done", bus.done, 0);
    check_eq("reset mode_req", bus.mode_req, 0);
    check_eq("reset mode_sel", bus.mode_sel, 0);
    check_eq("reset best_mode", bus.best_mode, 2);
    check_eq("reset best_sad", bus.best_sad, 4095);
    check_eq("reset tested", bus.tested, 0);
    reset = 1'b1;
    @(negedge clk);

    s = '{900, 800, 700, 600, 500, 400, 300, 200, 950};
    run_block("all_avail", 1'b1, 1'b1, 1'b1, s, 1, -1);

    s = '{999, 300, 300, 999, 999, 999, 999, 999, 100};
    run_block("left_only", 1'b0, 1'b1, 1'b0, s, 1, -1);

    s = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_block("none_avail", 1'b0, 1'b0, 1'b0, s, 1, -1);

    s = '{150, 150, 400, 500, 600, 700, 800, 900, 1000};
    run_block("tie_lat2", 1'b1, 1'b1, 1'b1, s, 2, -1);

    for (int k = 0; k < 9; k++) s[k] = int'($urandom_range(65, 4095));
    run_block("top_left_lat3", 1'b1, 1'b1, 1'b0, s, 3, -1);

    s = '{50, 500, 500, 500, 500, 500, 500, 500, 500};
    run_block("early", 1'b1, 1'b1, 1'b1, s, 1, -1);

    s = '{900, 800, 700, 600, 500, 400, 300, 200, 950};
    run_block("reset_mid", 1'b1, 1'b1, 1'b1, s, 1, 3);

    for (int k = 0; k < 9; k++) s[k] = int'($urandom_range(65, 4095));
    run_block("recover", 1'b1, 1'b1, 1'b1, s, 1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/intra4x4_mode_sched.md
# intra4x4_mode_sched

Controller that sequences the 4x4 luma intra predictors through the nine prediction modes of one 4x4 block, collects a SAD per mode from the downstream SAD unit, and reports the lowest-cost mode. It sits between the macroblock control FSM, which supplies start and neighbour availability, and the per-mode predictor and SAD datapath. It issues one mode at a time and skips modes whose reference samples are unavailable.

## Interface
Parameters:
- SAD_W, 12, width of SAD values (16 × 255 = 4080 fits in 12 bits)
- EARLY_THR, 64, early-termination threshold; used only when INTRA4X4_EARLY_TERM_EN is defined

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to evaluate a block; ignored while busy=1
- avail_top  in  1  top neighbours (A–D, E–H) are valid; sampled on an accepted start
- avail_left  in  1  left neighbours (I–L) are valid; sampled on an accepted start
- avail_topleft  in  1  corner neighbour M is valid; sampled on an accepted start
- mode_req  out  1  one-cycle strobe telling the datapath to evaluate mode_sel
- mode_sel  out  4  mode being issued, 0–8 in H.264 numbering; holds its value until the next issue
- sad_valid  in  1  SAD result for the outstanding mode is on sad_in
- sad_in  in  SAD_W  SAD of the outstanding mode
- busy  out  1  high from the cycle after an accepted start through the done cycle, inclusive
- done  out  1  one-cycle pulse; best_mode, best_sad and tested are valid from this cycle
- best_mode  out  4  lowest-SAD mode
- best_sad  out  SAD_W  SAD of best_mode
- tested  out  9  bit k set means mode k was evaluated

## Operation
- Mode eligibility, computed from the availability flags latched on start:
  - Mode 2 (DC) is always eligible.
  - Modes 0, 3, 7 require top.
  - Modes 1, 8 require left.
  - Modes 4, 5, 6 require top, left and topleft.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on start, latch the flags, build the pending mask (eligible modes), clear tested, and go to ISSUE.
  - ISSUE: assert mode_req for one cycle with mode_sel set to the lowest set bit of the pending mask. Clear that bit, then go to WAIT.
  - WAIT: hold until sad_valid. On that cycle, set the tested bit and compare:
    - If this is the first result, or sad_in < best_sad (strict), load best_mode/best_sad. Ties keep the lower mode number.
    - Then go to ISSUE if the pending mask is non-zero, otherwise go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Unavailable modes are skipped using a priority encoder on the pending mask, so no cycles are spent on them.
- sad_valid is ignored in IDLE, ISSUE and DONE.
- best_mode, best_sad and tested are registered. They hold their values after done until the next accepted start.
- Arithmetic: SAD compare is unsigned, SAD_W bits, with no bias or accumulation.

## Timing
- Reset values: busy=0, done=0, mode_req=0, mode_sel=0, best_mode=2, best_sad=all ones, tested=0, FSM=IDLE.
- Start is accepted in cycle t. The first mode_req is asserted in cycle t+1.
- Each mode costs 1 (ISSUE) + L cycles, where L ≥ 1 is the datapath latency from mode_req to sad_valid.
- Next ISSUE happens in the cycle after sad_valid. done is asserted in the cycle after the last sad_valid.
- With all neighbours available and L=1: 9 × 2 cycles, so done is asserted at t+19.
- Start arriving in the same cycle as done (FSM in DONE) is ignored. Start is accepted only in IDLE.
- Reset asserted mid-block: all state returns to reset values immediately. Any late sad_valid after reset is ignored.

## Configuration
- INTRA4X4_EARLY_TERM_EN defined: after the compare in WAIT, if best_sad ≤ EARLY_THR, go to DONE even when modes remain pending. Unevaluated modes stay 0 in tested.
- INTRA4X4_EARLY_TERM_EN undefined: all eligible modes are always evaluated, and EARLY_THR has no effect.

## Test plan
- All flags=1, L=1, SADs for modes 0–8 = 900,800,700,600,500,400,300,200,950. Expect:
  - mode_sel sequence 0..8;
  - best_mode=7, best_sad=200, tested=9'h1FF;
  - done at start+19.
- Flags top=0, left=1, topleft=0, SADs mode1=300, mode2=300, mode8=100. Expect:
  - mode_sel sequence 1, 2, 8;
  - best_mode=8, tested=9'h106.
- All flags=0, SAD=0. Expect:
  - only mode 2 issued;
  - best_mode=2, best_sad=0, tested=9'h004.
- Tie case: mode0=150 and mode1=150 are the lowest SADs. Expect best_mode=0.
- Reset pulse during WAIT of mode 3, followed by a stray sad_valid. Expect:
  - busy=0, tested=0 after reset;
  - no done, no state change.
- INTRA4X4_EARLY_TERM_EN defined, EARLY_THR=64, mode0=50. Expect:
  - done right after the first result;
  - best_mode=0, tested=9'h001.
